// File: rtl/display_count_scan_ctrl.sv
// 4-digit BCD up-counter with tick prescaler and parallel load, time-multiplexed
// onto a shared active-low seven-segment display one anode at a time.
module display_count_scan_ctrl #(
    parameter int TICK_DIV = 100_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] w,
    output logic [15:0] count,
    output logic        wrap,
    output logic [0:6]  seg,
    output logic [3:0]  digit
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] prescaler_reg;
    logic [SW-1:0] scan_cnt_reg;
    logic [1:0]    scan_idx_reg;
    logic [15:0]   count_reg;
    logic          wrap_reg;
    logic [0:6]    seg_reg;
    logic [3:0]    digit_reg;

    logic          tick;
    logic [15:0]   count_next;
    logic [15:0]   w_bcd;
    logic [4:0]    carry;
    logic [3:0]    sel_nib;

    assign tick     = enable && !load && (prescaler_reg == PW'(TICK_DIV - 1));
    assign carry[0] = 1'b1;

    // Decimal cascade: the whole carry chain resolves in one cycle.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] nib;
            logic [3:0] w_nib;
            assign nib   = count_reg[4*gi +: 4];
            assign w_nib = w[4*gi +: 4];
            assign carry[gi+1] = carry[gi] && (nib == 4'd9);
            assign count_next[4*gi +: 4] = !carry[gi]    ? nib :
                                           (nib == 4'd9) ? 4'd0 : nib + 4'd1;
            assign w_bcd[4*gi +: 4] = (w_nib > 4'd9) ? 4'd0 : w_nib;
        end
    endgenerate

    always_comb begin
        sel_nib = count_reg[3:0];
        case (scan_idx_reg)
            2'd0: sel_nib = count_reg[3:0];
            2'd1: sel_nib = count_reg[7:4];
            2'd2: sel_nib = count_reg[11:8];
            2'd3: sel_nib = count_reg[15:12];
            default: sel_nib = count_reg[3:0];
        endcase
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b0000001;
            4'd1:    seg_decode = 7'b1001111;
            4'd2:    seg_decode = 7'b0010010;
            4'd3:    seg_decode = 7'b0000110;
            4'd4:    seg_decode = 7'b1001100;
            4'd5:    seg_decode = 7'b0100100;
            4'd6:    seg_decode = 7'b0100000;
            4'd7:    seg_decode = 7'b0001111;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0000100;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_reg <= '0;
            scan_cnt_reg  <= '0;
            scan_idx_reg  <= 2'd0;
            count_reg     <= 16'h0000;
            wrap_reg      <= 1'b0;
            digit_reg     <= 4'b1110;
            seg_reg       <= 7'b0000001;
        end else begin
            // Load wins over a coincident tick; that tick is simply lost.
            if (load) begin
                count_reg     <= w_bcd;
                prescaler_reg <= '0;
                wrap_reg      <= 1'b0;
            end else if (tick) begin
                count_reg     <= count_next;
                prescaler_reg <= '0;
                wrap_reg      <= carry[4];
            end else begin
                if (enable)
                    prescaler_reg <= prescaler_reg + PW'(1);
                wrap_reg <= 1'b0;
            end

            if (scan_cnt_reg == SW'(SCAN_DIV - 1)) begin
                scan_cnt_reg <= '0;
                scan_idx_reg <= scan_idx_reg + 2'd1;
            end else begin
                scan_cnt_reg <= scan_cnt_reg + SW'(1);
            end

            digit_reg <= ~(4'b0001 << scan_idx_reg);
            seg_reg   <= seg_decode(sel_nib);
        end
    end

    assign count = count_reg;
    assign wrap  = wrap_reg;
    assign seg   = seg_reg;
    assign digit = digit_reg;
endmodule

// File: tb/tb_display_count_scan_ctrl.sv
// Bench for display_count_scan_ctrl: integer-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_display_count_scan_ctrl;
    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] w;
    logic [15:0] count;
    logic        wrap;
    logic [0:6]  seg;
    logic [3:0]  digit;

    display_count_scan_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .w(w),
        .count(count), .wrap(wrap), .seg(seg), .digit(digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Model state: count as a plain decimal integer, scan as elapsed cycles.
    int         m_count = 0;
    int         m_pre   = 0;
    int         m_scan  = 0;
    bit         m_wrap  = 0;
    logic [3:0] m_dig   = 4'b1110;
    logic [6:0] m_seg   = 7'b0000001;
    bit         m_valid = 0;

    logic [6:0] glyph [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100};
    int p10 [4] = '{1, 10, 100, 1000};

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int from_w(input logic [15:0] x);
        int v = 0;
        for (int i = 0; i < 4; i++) begin
            int d = int'(x[4*i +: 4]);
            if (d > 9) d = 0;
            v += d * p10[i];
        end
        return v;
    endfunction

    function automatic int m_idx();
        return (m_scan / SCAN_DIV) % 4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic model_update();
        if (reset) begin
            m_count = 0; m_pre = 0; m_scan = 0; m_wrap = 0;
            m_dig = 4'b1110; m_seg = glyph[0]; m_valid = 1;
        end else begin
            int idx = m_idx();
            m_dig  = ~(4'b0001 << idx);
            m_seg  = glyph[(m_count / p10[idx]) % 10];
            m_scan = (m_scan + 1) % (4 * SCAN_DIV);
            m_wrap = 0;
            if (load) begin
                m_count = from_w(w);
                m_pre   = 0;
            end else if (enable) begin
                if (m_pre == TICK_DIV - 1) begin
                    m_pre  = 0;
                    m_wrap = (m_count == 9999);
                    m_count = (m_count + 1) % 10000;
                end else begin
                    m_pre++;
                end
            end
        end
    endtask

    // One clock: advance the model on the edge, compare just after it.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        if (m_valid) begin
            check("count", count, to_bcd(m_count));
            check("wrap", wrap, m_wrap);
            check("digit", digit, m_dig);
            check("seg", seg, m_seg);
            check("digit_one_low", $countones(~digit), 1);
            $display("t=%0t en=%0b ld=%0b count=%h wrap=%0b digit=%b seg=%b",
                     $time, enable, load, count, wrap, digit, seg);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; load = 1'b0; w = 16'h0000;

        // Reset state and ten ticks in 40 enabled cycles.
        do_reset();
        check("rst_count", count, 16'h0000);
        check("rst_digit", digit, 4'b1110);
        check("rst_seg", seg, 7'b0000001);
        check("rst_wrap", wrap, 1'b0);
        enable = 1'b1;
        repeat (40) step();
        check("ten_ticks", count, 16'h0010);

        // Roll over 9999 -> 0000.
        load = 1'b1; w = 16'h9998;
        step();
        load = 1'b0;
        repeat (4) step();
        check("reach_9999", count, 16'h9999);
        repeat (3) step();
        check("no_wrap_yet", wrap, 1'b0);
        step();
        check("wrap_count", count, 16'h0000);
        check("wrap_pulse", wrap, 1'b1);
        step();
        check("wrap_drop", wrap, 1'b0);

        // Enable gap holds the prescaler.
        do_reset();
        enable = 1'b1;
        repeat (2) step();
        enable = 1'b0;
        repeat (10) step();
        enable = 1'b1;
        step();
        check("held_pre_1", count, 16'h0000);
        step();
        check("held_pre_2", count, 16'h0001);

        // Load coincides with a due tick; invalid nibble loads as zero.
        do_reset();
        enable = 1'b1;
        repeat (3) step();
        load = 1'b1; w = 16'h12F4;
        step();
        load = 1'b0;
        check("load_over_tick", count, 16'h1204);
        repeat (3) step();
        check("after_load_3", count, 16'h1204);
        step();
        check("after_load_4", count, 16'h1205);

        // Scan slots show the selected digit of 0375.
        enable = 1'b0; load = 1'b1; w = 16'h0375;
        step();
        load = 1'b0;
        repeat (12) begin
            step();
            if (m_dig == 4'b1101) check("slot1_seg7", seg, 7'b0001111);
            if (m_dig == 4'b1011) check("slot2_seg3", seg, 7'b0000110);
        end

        // Reset mid-count with index 2 selected.
        load = 1'b1; w = 16'h4567;
        step();
        load = 1'b0;
        for (int i = 0; i < 8 && m_idx() != 2; i++) step();
        check("idx2_reached", m_idx(), 2);
        check("pre_reset_count", count, 16'h4567);
        do_reset();
        check("mid_rst_count", count, 16'h0000);
        check("mid_rst_digit", digit, 4'b1110);
        check("mid_rst_seg", seg, 7'b0000001);
        check("mid_rst_wrap", wrap, 1'b0);
        enable = 1'b1;
        repeat (4) step();
        check("resume_count", count, 16'h0001);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset  = ($urandom_range(0, 199) == 0);
            load   = ($urandom_range(0, 29) == 0);
            enable = ($urandom_range(0, 3) != 0);
            w      = 16'($urandom);
            if ($urandom_range(0, 3) == 0) w = 16'h9998;
            step();
        end
        reset = 1'b0; load = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/display_count_scan_ctrl.md
Name: display_count_scan_ctrl

Overview:
Controller that sequences a 4-digit BCD up-counter and time-multiplexes it onto the board's shared seven-segment display. It contains a tick prescaler that paces counting, a synchronous parallel load, a decimal cascade across the four digits, and a refresh scheduler that selects one digit anode at a time and drives the segment bus with that digit's pattern. It sits between the switch/button inputs and the board display pins, and replaces per-digit free-running counter logic.

Parameters:
TICK_DIV, 100_000_000, clk cycles per count tick (1 s at 100 MHz); minimum 2.
SCAN_DIV, 100_000, clk cycles each digit stays selected (1 ms at 100 MHz); minimum 2.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high; one clock; no other clock/reset
enable  in  1  count enable; low freezes count and prescaler
load  in  1  synchronous parallel load of w into count
w  in  16  load value, 4 BCD nibbles, [3:0]=digit0 (least significant)
count  out  16  current BCD count, [3:0]=digit0
wrap  out  1  one-cycle pulse when count rolls 9999 -> 0000
seg  out  [0:6]  active-low segments a..g of the selected digit
digit  out  4  active-low anodes, exactly one low at all times

Behaviour:
- Reset (sync, highest priority, also mid-operation): count=0, prescaler=0, scan counter=0, scan index=0, wrap=0, digit=4'b1110, seg=7'b0000001 (glyph "0").
- Prescaler: when enable=1 and load=0, counts 0..TICK_DIV-1; tick is asserted internally in the cycle prescaler==TICK_DIV-1, and the prescaler returns to 0. When enable=0, the prescaler holds its value (it is not cleared).
- Load: load=1 (regardless of enable) -> count<=w on that edge and prescaler<=0. Any w nibble >9 loads as 0. Load overrides a coincident tick; that tick is discarded and wrap stays 0.
- Increment on tick: digit0+1. A digit at 9 becomes 0 and carries to the next digit. Carry propagates in the same cycle (count 0199 -> 0200 in one edge).
- Wrap-around: 9999 + tick -> 0000, with wrap=1 for exactly that one cycle. wrap=0 otherwise.
- count updates on the edge of the tick, so count is visible the cycle after prescaler==TICK_DIV-1.
- Scan scheduler: runs from reset independent of enable/load. The scan counter counts 0..SCAN_DIV-1; at SCAN_DIV-1 the scan index advances 0->1->2->3->0.
- Outputs digit and seg are registered: they reflect the scan index and count of the previous cycle (1-cycle latency). digit = ~(1<<index), so index 0 gives 4'b1110. seg is the active-low decode of count nibble[index]:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
- A count change while a digit is selected appears on seg one cycle later, with no wait for the next scan slot.
- Invariant: digit is never all-ones and never has more than one zero.

Test Plan:
- TICK_DIV=4, SCAN_DIV=2. Apply reset, then hold enable=1 for 40 cycles -> count=0010 (10 ticks); wrap never asserts; digit cycles 1110,1101,1011,0111 every 2 cycles.
- Load w=16'h9998 with enable=1, then run 8 cycles -> count 9999 then 0000; wrap high exactly one cycle, the cycle count becomes 0000.
- enable drops when prescaler=2, held low 10 cycles, then raised -> count changes 2 cycles after re-enable (prescaler was held, not cleared).
- Assert load with w=16'h12F4 in the same cycle a tick is due -> count=1204 (F nibble loads 0); no increment that cycle; the next tick comes 4 enabled cycles later.
- Count=0375, observe the index-1 slot -> one cycle after index becomes 1, digit=1101 and seg=0001111 ("7"); index 2 gives seg=0000110 ("3").
- Assert reset mid-count with count=4567 and index=2 -> the next cycle shows count=0000, digit=1110, seg=0000001, wrap=0; counting resumes from 0 after reset is released.
